bcd_display_ctrl: RTL
=====================

Name: bcd_display_ctrl

Overview:
Sequential binary-to-BCD conversion controller for the four-digit seven-segment display path. It accepts a binary value under a start/busy/done handshake and runs a shift-and-add-3 (double-dabble) conversion over N cycles. It then registers the four BCD digits and drives four seven-segment outputs: unidades, decenas, centenas, unidades de millar. It sits between the switch/value source and the board displays and replaces the purely combinational decode path.

Parameters:
N, 10, width of binary input; legal range 1..13, so that 2**N-1 <= 9999
SEG, 7, segments per display
BLANK_LZ, 1, 1 = blank leading-zero digits; the unidades digit is never blanked

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled only in IDLE
bin_in  input  N  binary value, latched on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when a new result is valid
bcd_out  output  16  registered BCD: [15:12] millar, [11:8] centenas, [7:4] decenas, [3:0] unidades
display_unidades  output  [0:SEG-1]  active-low segments, index 0 = a ... index 6 = g
display_decenas  output  [0:SEG-1]  same encoding
display_centenas  output  [0:SEG-1]  same encoding
display_unidades_millar  output  [0:SEG-1]  same encoding

Behaviour:
- One clock domain. Reset is asynchronous, active-low on rst_n.
- Reset values:
  - state = IDLE; busy = 0; done = 0; bcd_out = 0.
  - All displays = 7'b1111111 (blank).
  - Internal shift and scratch registers = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start = 1: latch bin_in into the shift register, clear the 16-bit BCD scratch, clear the iteration counter, go to SHIFT.
  - On start = 0: remain in IDLE.
- SHIFT (one iteration per cycle):
  - First, add 3 to each scratch nibble >= 5.
  - Then shift {scratch, shift_reg} left by one bit.
  - The counter increments each cycle; after N iterations, go to DONE.
- DONE:
  - bcd_out <= scratch; display registers update on the same edge.
  - done = 1 for exactly this cycle; next state is IDLE.
- busy = (state != IDLE).
- Latency: start accepted at edge k; done is high during the cycle following edge k+N+1. Minimum conversion period with start held high is N+2 cycles.
- start while busy (SHIFT or DONE) is ignored; bin_in changes while busy have no effect.
- Outputs hold the previous result during a conversion; there is no intermediate flicker.
- Segment table (a..g, active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Nibble values 10..15 (unreachable) map to blank.
- Leading-zero blanking (BLANK_LZ = 1): blank a digit when it and all higher digits are zero, except unidades. Value 0 shows "0" on unidades only.
- Reset mid-conversion: immediate return to reset values; the partial result is discarded. The next accepted start converts correctly.

Decomposition:
- Package bcd_pkg holds:
  - the state encoding (IDLE/SHIFT/DONE);
  - SEG_BLANK = 7'b1111111;
  - the digit-to-segment constant table;
  - the BCD nibble width (4) and digit count (4).
- One combinational sub-module, seg7_encoder (4-bit digit plus blank enable in, [0:6] segments out), instantiated four times.
- FSM and datapath stay in bcd_display_ctrl.

Test Plan:
1. Assert rst_n = 0 asynchronously, mid-cycle -> busy = 0, done = 0, bcd_out = 16'h0000, all four displays = 1111111 without waiting for a clock edge.
2. Pulse start with bin_in = 1023 -> busy rises next cycle; done pulses once, 11 cycles after the start edge; bcd_out = 16'h1023; displays: millar = 1001111, centenas = 0000001, decenas = 0010010, unidades = 0000110.
3. Pulse start with bin_in = 7, BLANK_LZ = 1 -> bcd_out = 16'h0007; unidades = 0001111; the other three displays = 1111111. Then bin_in = 0 -> unidades = 0000001, others blank.
4. Start with 512, then pulse start with 999 during SHIFT -> second request ignored; single done pulse; bcd_out = 16'h0512; no second done until a new start arrives in IDLE.
5. Start with 845, drop rst_n at iteration 5, release, then start with 300 -> reset values immediately; the subsequent done gives bcd_out = 16'h0300 with millar blanked.
6. Hold start = 1 with bin_in stepping 0..1023 on each done -> done period exactly 12 cycles; every bcd_out matches the decimal value (scoreboard compare across all 1024 values).

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display controller.
package bcd_pkg;

    localparam int BCD_W     = 4;
    localparam int DIGITS    = 4;
    localparam int SCRATCH_W = BCD_W * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Segment patterns are a..g left to right, active-low.
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_TABLE [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Double-dabble correction: any nibble of 5 or more gets 3 added before the shift.
    function automatic logic [SCRATCH_W-1:0] add3_nibbles(input logic [SCRATCH_W-1:0] v);
        logic [SCRATCH_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*BCD_W +: BCD_W] >= 4'd5) begin
                r[i*BCD_W +: BCD_W] = v[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// One BCD digit to active-low seven-segment pattern; non-decimal nibbles show blank.
module seg7_encoder
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (digit <= 4'd9)) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Start/busy/done controller running an N-cycle double-dabble conversion and
// registering the four BCD digits plus their seven-segment display patterns.
module bcd_display_ctrl
    import bcd_pkg::*;
#(
    parameter int N        = 10,
    parameter int SEG      = 7,
    parameter int BLANK_LZ = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   bin_in,
    output logic           busy,
    output logic           done,
    output logic [15:0]    bcd_out,
    output logic [0:SEG-1] display_unidades,
    output logic [0:SEG-1] display_decenas,
    output logic [0:SEG-1] display_centenas,
    output logic [0:SEG-1] display_unidades_millar
);

    localparam int CNT_W = $clog2(N + 1);

    state_t               state_q, state_d;
    logic [N-1:0]         shift_q, shift_d;
    logic [SCRATCH_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          bcd_q, bcd_d;
    logic                 done_q, done_d;
    logic [0:SEG-1]       disp_u_q, disp_u_d;
    logic [0:SEG-1]       disp_d_q, disp_d_d;
    logic [0:SEG-1]       disp_c_q, disp_c_d;
    logic [0:SEG-1]       disp_m_q, disp_m_d;

    logic [3:0] dig_u, dig_d, dig_c, dig_m;
    logic       blank_d, blank_c, blank_m;
    logic [0:6] seg_u, seg_d, seg_c, seg_m;

    assign dig_u = scratch_q[3:0];
    assign dig_d = scratch_q[7:4];
    assign dig_c = scratch_q[11:8];
    assign dig_m = scratch_q[15:12];

    // A digit is a leading zero only if every digit above it is zero as well.
    assign blank_m = (BLANK_LZ != 0) && (dig_m == 4'd0);
    assign blank_c = blank_m && (dig_c == 4'd0);
    assign blank_d = blank_c && (dig_d == 4'd0);

    seg7_encoder u_enc_u (.digit(dig_u), .blank(1'b0),    .seg(seg_u));
    seg7_encoder u_enc_d (.digit(dig_d), .blank(blank_d), .seg(seg_d));
    seg7_encoder u_enc_c (.digit(dig_c), .blank(blank_c), .seg(seg_c));
    seg7_encoder u_enc_m (.digit(dig_m), .blank(blank_m), .seg(seg_m));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        disp_u_d  = disp_u_q;
        disp_d_d  = disp_d_q;
        disp_c_d  = disp_c_q;
        disp_m_d  = disp_m_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {add3_nibbles(scratch_q), shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Visible outputs only change here, so a running conversion never flickers.
                bcd_d    = scratch_q;
                disp_u_d = seg_u;
                disp_d_d = seg_d;
                disp_c_d = seg_c;
                disp_m_d = seg_m;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            disp_u_q  <= SEG_BLANK;
            disp_d_q  <= SEG_BLANK;
            disp_c_q  <= SEG_BLANK;
            disp_m_q  <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            disp_u_q  <= disp_u_d;
            disp_d_q  <= disp_d_d;
            disp_c_q  <= disp_c_d;
            disp_m_q  <= disp_m_d;
        end
    end

    assign busy                    = (state_q != IDLE);
    assign done                    = done_q;
    assign bcd_out                 = bcd_q;
    assign display_unidades        = disp_u_q;
    assign display_decenas         = disp_d_q;
    assign display_centenas        = disp_c_q;
    assign display_unidades_millar = disp_m_q;

endmodule
